// File: rtl/inst_mem_ctrl_pkg.sv
// Shared types, constants and helpers for the instruction memory controller.
// Holds the FSM state encoding and the default NOP fill word (AND R0,R0,R0, cond AL).
package inst_mem_pkg;

  localparam int          BYTE_W       = 8;
  localparam logic [31:0] DEF_NOP_WORD = 32'hE000_0000;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Index width that never collapses to zero bits for tiny sizes.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Fetch request/response channel between PC logic (master) and instruction memory (slave).
// Request is valid/ready, response is a single registered buffer with valid/ready and flush.
interface inst_mem_ctrl_if
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 4 * BYTE_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [INST_W-1:0] rsp_inst;
  logic              rsp_err;
  logic              rsp_ready;
  logic              flush;

  modport master (
    output req_valid, req_addr, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );

endinterface

// File: rtl/inst_mem_ctrl_byte_ram.sv
// Byte-wide RAM: one byte write port (or a full word lane-write during fill) and a
// registered word read, big-endian (lowest address in MSBs), updated only on i_rd_en.
module inst_byte_ram
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WORD_BYTES  = 4,
  parameter int AW          = 10,
  parameter int WIW         = 8
) (
  input  logic                         clk,
  input  logic                         i_init_we,
  input  logic [WIW-1:0]               i_init_widx,
  input  logic [BYTE_W*WORD_BYTES-1:0] i_init_word,
  input  logic                         i_byte_we,
  input  logic [AW-1:0]                i_byte_addr,
  input  logic [BYTE_W-1:0]            i_byte,
  input  logic                         i_rd_en,
  input  logic [WIW-1:0]               i_rd_widx,
  output logic [BYTE_W*WORD_BYTES-1:0] o_rd_word
);

  localparam int INST_W = BYTE_W * WORD_BYTES;

  logic [BYTE_W-1:0] r_mem [DEPTH_BYTES];
  logic [INST_W-1:0] r_rd_word;

  always_ff @(posedge clk) begin
    if (i_init_we) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        r_mem[AW'(int'(i_init_widx) * WORD_BYTES + k)] <= i_init_word[INST_W-1-BYTE_W*k -: BYTE_W];
      end
    end else if (i_byte_we) begin
      r_mem[i_byte_addr] <= i_byte;
    end
  end

  // Read register holds its word between accepts so a stalled response stays stable.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        r_rd_word[INST_W-1-BYTE_W*k -: BYTE_W] <= r_mem[AW'(int'(i_rd_widx) * WORD_BYTES + k)];
      end
    end
  end

  assign o_rd_word = r_rd_word;

endmodule

// File: rtl/inst_mem_ctrl.sv
// Fetch-stage instruction memory: NOP fill after reset, byte-serial program load, 1-cycle fetch.
// Single-entry response buffer; req_ready drops while it is full and not being drained, or outside IDLE.
module inst_mem_ctrl
  import inst_mem_pkg::*;
#(
  parameter int                                ADDR_W      = 32,
  parameter int                                WORD_BYTES  = 4,
  parameter int                                DEPTH_BYTES = 1024,
  parameter logic [BYTE_W*WORD_BYTES-1:0]      NOP_WORD    = (BYTE_W*WORD_BYTES)'(DEF_NOP_WORD)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               o_init_done,
  input  logic                               i_load_start,
  input  logic                               i_load_en,
  input  logic [BYTE_W-1:0]                  i_load_byte,
  input  logic                               i_load_done,
  output logic [clog2_min1(DEPTH_BYTES)-1:0] o_load_ptr,
  inst_mem_ctrl_if.slave                     fetch
);

  localparam int INST_W = BYTE_W * WORD_BYTES;
  localparam int AW     = clog2_min1(DEPTH_BYTES);
  localparam int WBW    = $clog2(WORD_BYTES);
  localparam int NW     = DEPTH_BYTES / WORD_BYTES;
  localparam int WIW    = clog2_min1(NW);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WIW-1:0]    r_init_cnt;
  logic [AW-1:0]     r_load_ptr;
  logic [AW-1:0]     w_ptr_nxt;
  logic              w_init_we;
  logic              w_load_we;

  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rsp_nop;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_misalign;
  logic              w_oor;
  logic              w_bad;
  logic [WIW-1:0]    w_rd_widx;
  logic [INST_W-1:0] w_rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_load_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_load_ptr <= w_ptr_nxt;
      if (r_state == INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_load_ptr;
    w_init_we   = 1'b0;
    w_load_we   = 1'b0;
    case (r_state)
      INIT: begin
        w_init_we = 1'b1;
        if (r_init_cnt == WIW'(NW - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (i_load_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      LOAD: begin
        // A restart wins over a coincident byte; the pointer wraps naturally at DEPTH_BYTES.
        if (i_load_start) begin
          w_ptr_nxt = '0;
        end else if (i_load_en) begin
          w_load_we = 1'b1;
          w_ptr_nxt = r_load_ptr + 1'b1;
        end
        if (i_load_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  assign w_misalign  = |(fetch.req_addr & ADDR_W'(WORD_BYTES - 1));
  assign w_oor       = fetch.req_addr >= ADDR_W'(DEPTH_BYTES);
  assign w_bad       = w_misalign | w_oor;
  assign w_rd_widx   = WIW'(fetch.req_addr >> WBW);
  assign w_req_ready = (r_state == IDLE) && (!r_rsp_valid || fetch.rsp_ready);
  assign w_accept    = fetch.req_valid && w_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_nop   <= 1'b1;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_bad;
      r_rsp_nop   <= w_bad;
    end else if (fetch.flush || fetch.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  inst_byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WORD_BYTES  (WORD_BYTES),
    .AW          (AW),
    .WIW         (WIW)
  ) u_ram (
    .clk         (clk),
    .i_init_we   (w_init_we),
    .i_init_widx (r_init_cnt),
    .i_init_word (NOP_WORD),
    .i_byte_we   (w_load_we),
    .i_byte_addr (r_load_ptr),
    .i_byte      (i_load_byte),
    .i_rd_en     (w_accept),
    .i_rd_widx   (w_rd_widx),
    .o_rd_word   (w_rd_word)
  );

  // Error responses and the post-reset buffer present NOP without touching the RAM read path.
  assign fetch.rsp_inst  = r_rsp_nop ? NOP_WORD : w_rd_word;
  assign fetch.rsp_valid = r_rsp_valid;
  assign fetch.rsp_err   = r_rsp_err;
  assign fetch.req_ready = w_req_ready;
  assign o_init_done     = (r_state != INIT);
  assign o_load_ptr      = r_load_ptr;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl: fetch responses go through a scoreboard queue,
// address patterns come from a vector table, corner cases are hand-written sequences.
module tb_inst_mem_ctrl;

  localparam logic [31:0] NOP = 32'hE000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic       load_start;
  logic       load_en;
  logic [7:0] load_byte;
  logic       load_done;
  logic [9:0] load_ptr;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  inst_mem_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

  inst_mem_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_init_done  (init_done),
    .i_load_start (load_start),
    .i_load_en    (load_en),
    .i_load_byte  (load_byte),
    .i_load_done  (load_done),
    .o_load_ptr   (load_ptr),
    .fetch        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Responses are consumed on the edge after a negedge that sees valid & ready without flush.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%h required=no_response", bus.rsp_inst);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_inst", bus.rsp_inst, mon_e.inst);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (init_done) begin
        n = i;
        break;
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e);
    bit acc;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        sb.push_back('{inst: exp_i, err: exp_e});
        acc = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout actual=never_ready required=accept addr=%h", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic load_bytes(input logic [7:0] b[], input bit done_on_last);
    for (int i = 0; i < b.size(); i++) begin
      load_en   = 1'b1;
      load_byte = b[i];
      load_done = done_on_last && (i == b.size() - 1);
      @(posedge clk);
      #1;
      if (i == 3) chk("load_ptr_after_4", load_ptr, 4);
    end
    load_en   = 1'b0;
    load_done = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] prog[];

    vecs[0] = '{32'h0000_0000, 32'hE3A0_0014, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'hE280_0001, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'hE1A0_F00E, 1'b0};
    vecs[3] = '{32'h0000_000C, 32'hEAFF_FFFE, 1'b0};
    vecs[4] = '{32'h0000_0002, NOP,           1'b1};
    vecs[5] = '{32'h0000_0400, NOP,           1'b1};
    vecs[6] = '{32'h0000_03FC, NOP,           1'b0};
    vecs[7] = '{32'h0000_0001, NOP,           1'b1};
    vecs[8] = '{32'hFFFF_FFFC, NOP,           1'b1};
    vecs[9] = '{32'h0000_0010, NOP,           1'b0};

    rst_n = 1'b0;
    load_start = 0; load_en = 0; load_byte = 0; load_done = 0;
    bus.req_valid = 0; bus.req_addr = 0; bus.rsp_ready = 1; bus.flush = 0;

    repeat (3) @(negedge clk);
    chk("rst_init_done", {31'd0, init_done}, 0);
    chk("rst_load_ptr", {22'd0, load_ptr}, 0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_rsp_inst", bus.rsp_inst, NOP);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 0);
    rst_n = 1'b1;
    wait_init(n);
    chk("init_len", n, 256);

    fetch(32'h0, NOP, 1'b0);
    drain();

    // Program: four words, load_done coincident with the last byte.
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    prog = '{8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE2, 8'h80, 8'h00, 8'h01,
             8'hE1, 8'hA0, 8'hF0, 8'h0E, 8'hEA, 8'hFF, 8'hFF, 8'hFE};
    load_bytes(prog, 1'b1);
    chk("load_ptr_16", {22'd0, load_ptr}, 16);
    fetch(32'h0, 32'hE3A0_0014, 1'b0);
    drain();

    // Table vectors at full throughput.
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = vecs[i].addr;
      @(negedge clk);
      chk("tbl_req_ready", {31'd0, bus.req_ready}, 1);
      if (bus.req_ready) sb.push_back('{inst: vecs[i].inst, err: vecs[i].err});
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    drain();

    // Back-pressure: buffer held for 3 cycles, next fetch accepted the cycle ready returns.
    bus.rsp_ready = 1'b0;
    fetch(32'h0, 32'hE3A0_0014, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 0);
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 1);
      chk("bp_rsp_inst", bus.rsp_inst, 32'hE3A0_0014);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, bus.req_ready}, 1);
    if (bus.req_ready) sb.push_back('{inst: 32'hE280_0001, err: 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain();

    // Flush with no request discards the buffered response.
    bus.rsp_ready = 1'b0;
    fetch(32'h0, 32'hE3A0_0014, 1'b0);
    chk("fl_before_valid", {31'd0, bus.rsp_valid}, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("fl_valid_cleared", {31'd0, bus.rsp_valid}, 0);
    if (sb.size() != 0) void'(sb.pop_front());

    // Flush plus an accepted fetch loads the new response.
    fetch(32'hC, 32'hEAFF_FFFE, 1'b0);
    bus.flush     = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    @(negedge clk);
    chk("fl_acc_ready", {31'd0, bus.req_ready}, 1);
    if (sb.size() != 0) void'(sb.pop_front());
    sb.push_back('{inst: 32'hE1A0_F00E, err: 1'b0});
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("fl_acc_valid", {31'd0, bus.rsp_valid}, 1);
    chk("fl_acc_inst", bus.rsp_inst, 32'hE1A0_F00E);
    bus.rsp_ready = 1'b1;
    drain();

    // 1025 bytes: pointer wraps and the last byte overwrites address 0.
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 1025; i++) begin
      load_en   = 1'b1;
      load_byte = (i < 1024) ? 8'(i) : 8'hA5;
      @(posedge clk); #1;
    end
    load_en = 1'b0;
    chk("wrap_load_ptr", {22'd0, load_ptr}, 1);
    load_done = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
    fetch(32'h0, 32'hA501_0203, 1'b0);
    fetch(32'h3FC, 32'hFCFD_FEFF, 1'b0);
    drain();

    // Reset mid-LOAD, then a fresh fill.
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_en    = 1'b1;
    load_byte  = 8'h11;
    repeat (2) begin @(posedge clk); #1; end
    load_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_init_done", {31'd0, init_done}, 0);
    chk("mid_rst_load_ptr", {22'd0, load_ptr}, 0);
    chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit_len", n, 256);
    fetch(32'h0, NOP, 1'b0);
    fetch(32'h3FC, NOP, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
